// File: rtl/isqrt_seq_pkg.sv
// Shared definitions for the integer square-root sequencer: state encoding and default width.
package isqrt_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_W = 16;

endpackage

// File: rtl/isqrt_datapath.sv
// Odd-number recurrence datapath: s/sq/odd/i registers, W+1-bit add/compare and rem subtractor.
module isqrt_datapath #(
    parameter int W = 16
) (
    input  logic           c,
    input  logic           reset_n,
    input  logic           load,
    input  logic           step,
    input  logic           latch,
    input  logic [W-1:0]   s_in,
    output logic           fits,
    output logic [W/2-1:0] root_o,
    output logic [W-1:0]   rem_o
);
    localparam int RW = W / 2;
    localparam logic [RW:0]   ODD_ONE = (RW + 1)'(1);
    localparam logic [RW:0]   ODD_TWO = (RW + 1)'(2);
    localparam logic [RW-1:0] I_ONE   = RW'(1);

    logic [W-1:0]  r_s;
    logic [W-1:0]  r_sq;
    logic [RW:0]   r_odd;
    logic [RW-1:0] r_i;
    logic [W:0]    w_t;

    // One extra bit so sq+odd reaching 2^W compares as larger than any W-bit s.
    assign w_t   = {1'b0, r_sq} + {{(W - RW){1'b0}}, r_odd};
    assign fits  = (w_t <= {1'b0, r_s});

    assign root_o = latch ? r_i : '0;
    assign rem_o  = latch ? (r_s - r_sq) : '0;

    always_ff @(posedge c) begin
        if (!reset_n) begin
            r_s   <= '0;
            r_sq  <= '0;
            r_odd <= '0;
            r_i   <= '0;
        end else if (load) begin
            r_s   <= s_in;
            r_sq  <= '0;
            r_odd <= ODD_ONE;
            r_i   <= '0;
        end else if (step) begin
            r_sq  <= w_t[W-1:0];
            r_odd <= r_odd + ODD_TWO;
            r_i   <= r_i + I_ONE;
        end
    end

endmodule

// File: rtl/isqrt_seq.sv
// Integer square-root sequencer: IDLE/RUN/DONE controller around isqrt_datapath.
// Handshake: start is sampled only in IDLE; done is a one-cycle pulse, root/rem hold until the next completion.
module isqrt_seq
    import isqrt_seq_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           c,
    input  logic           reset_n,
    input  logic           start,
    input  logic [W-1:0]   s_in,
    output logic           busy,
    output logic           done,
    output logic [W/2-1:0] root,
    output logic [W-1:0]   rem,
    output state_e         state_dbg
);
    state_e         r_state;
    logic           w_load;
    logic           w_step;
    logic           w_latch;
    logic           w_fits;
    logic [W/2-1:0] w_root;
    logic [W-1:0]   w_rem;

    assign w_load    = (r_state == ST_IDLE) && start;
    assign w_step    = (r_state == ST_RUN) && w_fits;
    assign w_latch   = (r_state == ST_RUN) && !w_fits;
    assign state_dbg = r_state;

    isqrt_datapath #(.W(W)) u_dp (
        .c       (c),
        .reset_n (reset_n),
        .load    (w_load),
        .step    (w_step),
        .latch   (w_latch),
        .s_in    (s_in),
        .fits    (w_fits),
        .root_o  (w_root),
        .rem_o   (w_rem)
    );

    always_ff @(posedge c) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            root    <= '0;
            rem     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= ST_RUN;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_fits) begin
                        root    <= w_root;
                        rem     <= w_rem;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
